// File: rtl/core.sv
// Shared core types: branch redirect bus, fetch FSM states and the fetch-to-decode payload.
package core;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic            is_taken;
        logic [XLEN-1:0] branch_target;
    } br_cntrl_bus_t;

    typedef enum logic [1:0] {
        FS_BOOT,
        FS_RUN,
        FS_SQUASH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_bus_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of if_bus_t entries with clear, occupancy count and full/empty flags.
module fetch_fifo
    import core::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  if_bus_t          data_i,
    input  logic             pop_i,
    output if_bus_t          data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if_bus_t          r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues imem requests, buffers responses
// for decode and squashes stale work on a branch redirect.
module fetch_unit
    import core::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  br_cntrl_bus_t br_bus_i,
    output logic          imem_req_o,
    output logic [31:0]   imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [31:0]   imem_rdata_i,
    output logic          if_valid_o,
    output logic [31:0]   if_instr_o,
    output logic [31:0]   if_pc_o,
    input  logic          if_ready_i
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] w_out_nxt;
    logic [CNT_W-1:0] w_drop_nxt;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W-1:0] w_pcq_count;
    logic [CNT_W-1:0] w_occupancy;
    logic             w_req;
    logic             w_grant;
    logic             w_resp;
    logic             w_push;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_pcq_empty;
    logic             w_pcq_full;
    if_bus_t          w_fifo_head;
    if_bus_t          w_pcq_head;
    logic             w_unused;

    // Occupancy counts only in-flight requests that will land in the buffer, so every grant has a slot.
    assign w_occupancy = w_fifo_count + (r_outstanding - r_drop);
    assign w_req       = (r_state != FS_BOOT) & ~flush_i
                       & (w_occupancy < CNT_W'(FIFO_DEPTH))
                       & (r_outstanding < CNT_W'(MAX_OUTSTANDING));
    assign w_grant     = w_req & imem_gnt_i;
    assign w_resp      = imem_rvalid_i & (r_outstanding != '0);
    assign w_push      = w_resp & (r_drop == '0) & ~flush_i;

    // On redirect every request still in flight after this cycle is stale.
    always_comb begin
        w_out_nxt  = r_outstanding;
        w_drop_nxt = r_drop;
        if (w_grant && !w_resp) begin
            w_out_nxt = r_outstanding + CNT_W'(1);
        end else if (w_resp && !w_grant) begin
            w_out_nxt = r_outstanding - CNT_W'(1);
        end
        if (flush_i) begin
            w_drop_nxt = w_out_nxt;
        end else if (w_resp && (r_drop != '0)) begin
            w_drop_nxt = r_drop - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= FS_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FS_BOOT:   w_state_nxt = FS_RUN;
            FS_RUN:    w_state_nxt = FS_RUN;
            FS_SQUASH: if (w_drop_nxt == '0) w_state_nxt = FS_RUN;
            default:   w_state_nxt = FS_BOOT;
        endcase
        if (flush_i) begin
            w_state_nxt = (w_drop_nxt != '0) ? FS_SQUASH : FS_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            if (flush_i) begin
                r_pc <= {br_bus_i.branch_target[31:2], 2'b00};
            end else if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end
            r_outstanding <= w_out_nxt;
            r_drop        <= w_drop_nxt;
        end
    end

    // Granted addresses in order; stale responses pop it as well, keeping it aligned.
    fetch_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_pc_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (1'b0),
        .push_i  (w_grant),
        .data_i  ('{instr: 32'h0, pc: r_pc}),
        .pop_i   (w_resp),
        .data_o  (w_pcq_head),
        .count_o (w_pcq_count),
        .full_o  (w_pcq_full),
        .empty_o (w_pcq_empty)
    );

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_ibuf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (w_push),
        .data_i  ('{instr: imem_rdata_i, pc: w_pcq_head.pc}),
        .pop_i   (if_ready_i),
        .data_o  (w_fifo_head),
        .count_o (w_fifo_count),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;
    assign if_valid_o  = ~w_fifo_empty;
    assign if_instr_o  = w_fifo_head.instr;
    assign if_pc_o     = w_fifo_head.pc;

    assign w_unused = ^{br_bus_i.is_taken, br_bus_i.branch_target[1:0], w_pcq_head.instr,
                        w_pcq_count, w_pcq_full, w_pcq_empty, w_fifo_full};

    a_rsp_has_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> (r_outstanding != '0));

endmodule
